rnn_cell_param: RTL and testbench

Parametrised next-generation RNN cell accelerator on the same 3-bit-address, 32-bit memory-mapped slave bus as the existing RNN block. It holds the input, weight, recurrent, bias and dense parameters in on-chip register arrays. A single serial MAC computes one step h' = act(W·x + U·h + b), and a separate command computes the dense output y = d·h + db. Additions over the previous generation: configurable sizes and fixed-point point, saturating arithmetic, double-buffered hidden state, a step counter, an explicit clear command, and a sticky bus error flag.

---
 rtl/rnn_cell_param.sv | 227 ++++++++++++++++++++++
 tb/tb_rnn_cell_param.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rnn_cell_param.sv
// Parametrised RNN cell on a 3-bit-address, 32-bit memory-mapped slave bus.
// One serial MAC computes h' = act(W*x + U*h + b) per step and y = d*h + db on command.
module rnn_cell_param #(
  parameter int EMB_LEN = 4,
  parameter int HID_LEN = 32,
  parameter int FRAC    = 8,
  parameter int ACT     = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        read,
  input  logic        write,
  input  logic [2:0]  addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out
);

  localparam int EW    = (EMB_LEN > 1) ? $clog2(EMB_LEN) : 1;
  localparam int HW    = (HID_LEN > 1) ? $clog2(HID_LEN) : 1;
  localparam int KW    = $clog2(EMB_LEN + HID_LEN + 1);
  localparam int ONE_I = (FRAC >= 15) ? 32767 : (1 << FRAC);
  localparam logic signed [15:0] POS_LIM = 16'(ONE_I);
  localparam logic signed [15:0] NEG_LIM = 16'(-ONE_I);

  typedef enum logic [2:0] {IDLE, MAC, STORE, COMMIT, DENSE, DBIAS, VALID} state_t;

  state_t state, state_nxt;

  logic [15:0] x_mem  [EMB_LEN];
  logic [15:0] w_mem  [HID_LEN][EMB_LEN];
  logic [15:0] u_mem  [HID_LEN][HID_LEN];
  logic [15:0] b_mem  [HID_LEN];
  logic [15:0] d_mem  [HID_LEN];
  logic [15:0] h_mem  [HID_LEN];
  logic [15:0] h_next [HID_LEN];
  logic [15:0] db;
  logic [15:0] result;
  logic [15:0] step_cnt;
  logic        err;

  logic signed [31:0] acc;
  logic [HW-1:0]      row;
  logic [KW-1:0]      k;

  function automatic logic [31:0] sx32(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  function automatic logic [15:0] sat16(input logic signed [31:0] v);
    if (v > 32'sd32767)       return 16'h7fff;
    else if (v < -32'sd32768) return 16'h8000;
    else                      return v[15:0];
  endfunction

  function automatic logic [15:0] act(input logic [15:0] v);
    logic signed [15:0] s;
    s = v;
    if (ACT == 0) begin
      if (s > POS_LIM)      return POS_LIM;
      else if (s < NEG_LIM) return NEG_LIM;
    end
    return v;
  endfunction

  // Bus decode: [15:0] value, [23:16] index/column, [31:24] row
  logic [15:0] wr_val;
  logic [7:0]  wr_idx, wr_row;
  logic        wr_idle, start, cmd;
  logic        emb_ok, hid_ok, row_ok;
  logic        last_term, last_row, last_d;

  assign wr_val    = data_in[15:0];
  assign wr_idx    = data_in[23:16];
  assign wr_row    = data_in[31:24];
  assign wr_idle   = write && (state == IDLE);
  assign start     = wr_idle && (addr == 3'd0);
  assign cmd       = wr_idle && (addr == 3'd7);
  assign emb_ok    = int'(wr_idx) < EMB_LEN;
  assign hid_ok    = int'(wr_idx) < HID_LEN;
  assign row_ok    = int'(wr_row) < HID_LEN;
  assign last_term = (k == KW'(EMB_LEN + HID_LEN - 1));
  assign last_d    = (k == KW'(HID_LEN - 1));
  assign last_row  = (row == HW'(HID_LEN - 1));

  // Operand select: x/W terms first, then h/U terms; DENSE walks h/d
  logic [15:0]        mac_a, mac_b;
  logic signed [31:0] prod, term;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    mac_a = '0;
    mac_b = '0;
    if (state == DENSE) begin
      mac_a = h_mem[HW'(k)];
      mac_b = d_mem[HW'(k)];
    end else if (k < KW'(EMB_LEN)) begin
      mac_a = x_mem[EW'(k)];
      mac_b = w_mem[row][EW'(k)];
    end else begin
      mac_a = h_mem[HW'(k - KW'(EMB_LEN))];
      mac_b = u_mem[row][HW'(k - KW'(EMB_LEN))];
    end
  end

  assign prod = $signed(mac_a) * $signed(mac_b);
  assign term = prod >>> FRAC;

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state always uses non-blocking assignment.
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start)                   state_nxt = MAC;
        else if (cmd && data_in[0])  state_nxt = DENSE;
      end
      MAC:    if (last_term) state_nxt = STORE;
      STORE:  state_nxt = last_row ? COMMIT : MAC;
      COMMIT: state_nxt = IDLE;
      DENSE:  if (last_d) state_nxt = DBIAS;
      DBIAS:  state_nxt = VALID;
      VALID:  if (read && addr == 3'd7) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the parameter arrays are registers, not RAM, so they reset with everything else.
      for (int i = 0; i < EMB_LEN; i++) x_mem[i] <= '0;
      for (int r = 0; r < HID_LEN; r++) begin
        b_mem[r]  <= '0;
        d_mem[r]  <= '0;
        h_mem[r]  <= '0;
        h_next[r] <= '0;
        for (int c = 0; c < EMB_LEN; c++) w_mem[r][c] <= '0;
        for (int c = 0; c < HID_LEN; c++) u_mem[r][c] <= '0;
      end
      db       <= '0;
      result   <= '0;
      step_cnt <= '0;
      err      <= 1'b0;
      acc      <= '0;
      row      <= '0;
      k        <= '0;
    end else begin
      if (write && state != IDLE)      err <= 1'b1;
      else if (read && addr == 3'd0)   err <= 1'b0;

      if (wr_idle) begin
        case (addr)
          3'd0: begin
            row <= '0;
            k   <= '0;
            acc <= sx32(b_mem[0]);
          end
          3'd1: if (emb_ok) x_mem[EW'(wr_idx)] <= wr_val;
          3'd2: if (row_ok && emb_ok) w_mem[HW'(wr_row)][EW'(wr_idx)] <= wr_val;
          3'd3: if (row_ok && hid_ok) u_mem[HW'(wr_row)][HW'(wr_idx)] <= wr_val;
          3'd4: if (hid_ok) b_mem[HW'(wr_idx)] <= wr_val;
          3'd5: if (hid_ok) d_mem[HW'(wr_idx)] <= wr_val;
          3'd6: db <= wr_val;
          default: begin
            // Clear lands on this edge, so a dense run started alongside sees h = 0
            if (data_in[1]) begin
              for (int r = 0; r < HID_LEN; r++) begin
                h_mem[r]  <= '0;
                h_next[r] <= '0;
              end
              step_cnt <= '0;
            end
            if (data_in[0]) begin
              k   <= '0;
              acc <= '0;
            end
          end
        endcase
      end

      case (state)
        MAC: begin
          acc <= acc + term;
          k   <= last_term ? '0 : k + KW'(1);
        end
        STORE: begin
          h_next[row] <= act(sat16(acc));
          if (!last_row) begin
            row <= row + HW'(1);
            acc <= sx32(b_mem[row + HW'(1)]);
          end
        end
        COMMIT: begin
          for (int r = 0; r < HID_LEN; r++) h_mem[r] <= h_next[r];
          step_cnt <= step_cnt + 16'd1;
        end
        DENSE: begin
          acc <= acc + term;
          k   <= k + KW'(1);
        end
        DBIAS: result <= sat16(acc + sx32(db));
        default: ;
      endcase
    end
  end

  logic st_valid, st_idle, st_busy;
  assign st_valid = (state == VALID);
  assign st_idle  = (state == IDLE);
  assign st_busy  = !(st_valid || st_idle);

  always_comb begin
    data_out = '0;
    if (read) begin
      case (addr)
        3'd0:    data_out = {28'd0, err, st_busy, st_idle, st_valid};
        3'd6:    data_out = sx32(step_cnt);
        3'd7:    data_out = sx32(result);
        default: data_out = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_rnn_cell_param.sv
// Directed bench for rnn_cell_param (EMB=2, HID=2, FRAC=8): table of bus
// operations with hand-computed expectations plus exact-latency and reset sequences.
module tb_rnn_cell_param;

  localparam int E = 2;
  localparam int H = 2;
  localparam int F = 8;
  localparam int STEP_CYC = H * (E + H + 1) + 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        read, write;
  logic [2:0]  addr;
  logic [31:0] data_in;
  logic [31:0] data_out, data_out_id;

  always #5 clk = ~clk;

  rnn_cell_param #(.EMB_LEN(E), .HID_LEN(H), .FRAC(F), .ACT(0)) dut (
    .clk(clk), .rst_n(rst_n), .read(read), .write(write),
    .addr(addr), .data_in(data_in), .data_out(data_out)
  );

  rnn_cell_param #(.EMB_LEN(E), .HID_LEN(H), .FRAC(F), .ACT(1)) dut_id (
    .clk(clk), .rst_n(rst_n), .read(read), .write(write),
    .addr(addr), .data_in(data_in), .data_out(data_out_id)
  );

  int n_checks = 0;
  int n_errors = 0;

  typedef enum {OP_WR, OP_RD, OP_PEEK, OP_WAIT} op_e;
  typedef struct {
    op_e         op;
    logic [2:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
    logic        chk_id;
    logic [31:0] exp_id;
    string       name;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input op_e op, input logic [2:0] a, input logic [31:0] d,
                              input logic [31:0] exp, input logic chk_id,
                              input logic [31:0] exp_id, input string name);
    vec_t v;
    v.op = op; v.addr = a; v.data = d; v.exp = exp;
    v.chk_id = chk_id; v.exp_id = exp_id; v.name = name;
    vecs.push_back(v);
  endfunction

  function automatic void w(input logic [2:0] a, input int r, input int c, input logic [15:0] v);
    add(OP_WR, a, {8'(r), 8'(c), v}, 32'h0, 1'b0, 32'h0, "");
  endfunction

  function automatic void rd(input logic [2:0] a, input logic [31:0] exp, input string name);
    add(OP_RD, a, 32'h0, exp, 1'b0, 32'h0, name);
  endfunction

  function automatic void rd2(input logic [31:0] exp, input logic [31:0] exp_id, input string name);
    add(OP_RD, 3'd7, 32'h0, exp, 1'b1, exp_id, name);
  endfunction

  function automatic void pk(input logic [31:0] exp, input string name);
    add(OP_PEEK, 3'd0, 32'h0, exp, 1'b0, 32'h0, name);
  endfunction

  function automatic void wt(input logic [31:0] mask, input string name);
    add(OP_WAIT, 3'd0, mask, 32'h0, 1'b0, 32'h0, name);
  endfunction

  // Start a step and wait for idle; run a dense command and wait for valid
  function automatic void step(input string name);
    w(3'd0, 0, 0, 16'h0);
    wt(32'h2, name);
  endfunction

  function automatic void dense(input logic [15:0] c, input string name);
    w(3'd7, 0, 0, c);
    wt(32'h1, name);
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h, expected %08h", name, got, exp);
    end
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    write = 1'b1; addr = a; data_in = d;
    @(posedge clk);
    #1;
    write = 1'b0; data_in = '0;
  endtask

  task automatic bus_read(input logic [2:0] a, input logic [31:0] exp, input logic chk_id,
                          input logic [31:0] exp_id, input string name);
    @(negedge clk);
    read = 1'b1; addr = a;
    #1;
    check(name, data_out, exp);
    if (chk_id) check({name, "_id"}, data_out_id, exp_id);
    @(posedge clk);
    #1;
    read = 1'b0;
  endtask

  // Combinational look without letting a clock edge see the strobe
  task automatic peek(input logic [2:0] a, input logic [31:0] exp, input string name);
    read = 1'b1; addr = a;
    #1;
    check(name, data_out, exp);
    read = 1'b0;
    #1;
  endtask

  task automatic wait_status(input logic [31:0] mask, input string name);
    int  cyc;
    bit  seen;
    logic [31:0] last;
    cyc = 0; seen = 1'b0; last = '0;
    while (!seen && cyc < 500) begin
      @(negedge clk);
      read = 1'b1; addr = 3'd0;
      #1;
      last = data_out;
      seen = (data_out & mask) != 0;
      read = 1'b0;
      cyc++;
    end
    n_checks++;
    if (!seen) begin
      n_errors++;
      $display("FAIL %s: status %08h, required bit mask %08h within 500 cycles", name, last, mask);
    end
  endtask

  task automatic run_table();
    foreach (vecs[i]) begin
      case (vecs[i].op)
        OP_WR:   bus_write(vecs[i].addr, vecs[i].data);
        OP_RD:   bus_read(vecs[i].addr, vecs[i].exp, vecs[i].chk_id, vecs[i].exp_id, vecs[i].name);
        OP_PEEK: begin @(negedge clk); peek(vecs[i].addr, vecs[i].exp, vecs[i].name); end
        default: wait_status(vecs[i].data, vecs[i].name);
      endcase
    end
    vecs.delete();
  endtask

  task automatic step_latency(input string name);
    bus_write(3'd0, 32'h0);
    repeat (STEP_CYC - 1) @(posedge clk);
    #1;
    peek(3'd0, 32'h4, {name, "_busy_before"});
    @(posedge clk);
    #1;
    peek(3'd0, 32'h2, {name, "_idle_exact"});
  endtask

  task automatic dense_latency(input logic [31:0] c, input string name);
    bus_write(3'd7, c);
    repeat (H) @(posedge clk);
    #1;
    peek(3'd0, 32'h4, {name, "_busy_before"});
    @(posedge clk);
    #1;
    peek(3'd0, 32'h1, {name, "_valid_exact"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; read = 1'b0; write = 1'b0; addr = '0; data_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    pk(32'h2, "rst_status");
    rd(3'd7, 32'h0, "rst_result");
    rd(3'd6, 32'h0, "rst_step");
    rd(3'd3, 32'h0, "unmapped_read");
    // Test 1: W = identity, x = {0.5, -0.5}
    w(3'd1, 0, 0, 16'h0080);
    w(3'd1, 0, 1, 16'hFF80);
    w(3'd2, 0, 0, 16'h0100);
    w(3'd2, 1, 1, 16'h0100);
    run_table();
    step_latency("t1_step");

    w(3'd5, 0, 0, 16'h0100);
    dense(16'h1, "t1_dense_wait");
    rd2(32'h0000_0080, 32'h0000_0080, "t1_result");
    pk(32'h2, "t1_back_to_idle");
    rd(3'd6, 32'h1, "t1_step_cnt");
    w(3'd5, 0, 0, 16'h0000);
    w(3'd5, 0, 1, 16'h0100);
    dense(16'h1, "t1_dense2_wait");
    rd(3'd7, 32'hFFFF_FF80, "t1_neg_h1");
    run_table();
    @(negedge clk);
    addr = 3'd7; read = 1'b0;
    #1;
    check("read_low_gives_zero", data_out, 32'h0);

    // Test 2: saturation before hard-tanh vs identity
    w(3'd1, 0, 0, 16'h0300);
    w(3'd4, 0, 0, 16'h7F00);
    w(3'd4, 0, 1, 16'h8100);
    step("t2_step_wait");
    w(3'd5, 0, 0, 16'h0100);
    w(3'd5, 0, 1, 16'h0000);
    dense(16'h1, "t2_dense_wait");
    rd2(32'h0000_0100, 32'h0000_7FFF, "t2_sat_pos");
    w(3'd5, 0, 0, 16'h0000);
    w(3'd5, 0, 1, 16'h0100);
    dense(16'h1, "t2_dense2_wait");
    rd2(32'hFFFF_FF00, 32'hFFFF_8080, "t2_sat_neg");

    // Test 3: recurrence, h1' = h0 + h1 exposes use of new h0
    w(3'd7, 0, 0, 16'h2);
    w(3'd2, 0, 0, 16'h0000);
    w(3'd2, 1, 1, 16'h0000);
    w(3'd3, 0, 0, 16'h0100);
    w(3'd3, 1, 0, 16'h0100);
    w(3'd3, 1, 1, 16'h0100);
    w(3'd4, 0, 0, 16'h0010);
    w(3'd4, 0, 1, 16'h0000);
    step("t3_step1_wait");
    step("t3_step2_wait");
    step("t3_step3_wait");
    rd(3'd6, 32'h3, "t3_step_cnt");
    w(3'd5, 0, 0, 16'h0100);
    w(3'd5, 0, 1, 16'h0000);
    dense(16'h1, "t3_dense_wait");
    rd(3'd7, 32'h0000_0030, "t3_h0");
    w(3'd5, 0, 1, 16'h0200);
    dense(16'h1, "t3_dense2_wait");
    rd(3'd7, 32'h0000_0090, "t3_double_buffer");

    // Test 4: h = {0x80, 0x40}, then dense
    w(3'd7, 0, 0, 16'h2);
    w(3'd3, 0, 0, 16'h0000);
    w(3'd3, 1, 0, 16'h0000);
    w(3'd3, 1, 1, 16'h0000);
    w(3'd2, 0, 0, 16'h0100);
    w(3'd2, 1, 1, 16'h0100);
    w(3'd1, 0, 0, 16'h0080);
    w(3'd1, 0, 1, 16'h0040);
    w(3'd4, 0, 0, 16'h0000);
    step("t4_step_wait");
    w(3'd5, 0, 0, 16'h0100);
    w(3'd5, 0, 1, 16'h0200);
    w(3'd6, 0, 0, 16'h0010);
    run_table();
    dense_latency(32'h1, "t4_dense");
    rd(3'd7, 32'h0000_0110, "t4_dense_result");
    w(3'd5, 0, 0, 16'h8000);
    w(3'd5, 0, 1, 16'h8000);
    w(3'd6, 0, 0, 16'h8000);
    dense(16'h1, "t4_dense2_wait");
    rd(3'd7, 32'hFFFF_8000, "t4_neg_clamp");
    run_table();

    // Test 5: write during MAC sets err; read of status clears it
    bus_write(3'd0, 32'h0);
    bus_write(3'd2, {8'd0, 8'd0, 16'h1234});
    peek(3'd0, 32'hC, "t5_err_busy");
    wt(32'h2, "t5_step_wait");
    pk(32'hA, "t5_err_idle");
    rd(3'd0, 32'hA, "t5_err_read");
    pk(32'h2, "t5_err_cleared");
    w(3'd1, 0, 5, 16'h7000);
    w(3'd4, 0, 4, 16'h7000);
    w(3'd2, 5, 0, 16'h7000);
    w(3'd2, 0, 3, 16'h7000);
    pk(32'h2, "t5_range_no_err");
    step("t5_step2_wait");
    w(3'd5, 0, 0, 16'h0100);
    w(3'd5, 0, 1, 16'h0100);
    w(3'd6, 0, 0, 16'h0000);
    dense(16'h1, "t5_dense_wait");
    rd(3'd7, 32'h0000_00C0, "t5_ignored_writes");
    rd(3'd6, 32'h3, "t5_step_cnt");

    // Test 6: clear + dense, then reset mid-MAC
    w(3'd6, 0, 0, 16'h0055);
    dense(16'h3, "t6_dense_wait");
    rd(3'd7, 32'h0000_0055, "t6_clear_dense");
    rd(3'd6, 32'h0, "t6_step_cleared");
    step("t6_step_wait");
    run_table();

    bus_write(3'd0, 32'h0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    peek(3'd0, 32'h2, "t6_rst_status");
    peek(3'd7, 32'h0, "t6_rst_result");
    peek(3'd6, 32'h0, "t6_rst_step");
    @(negedge clk);
    rst_n = 1'b1;

    w(3'd1, 0, 0, 16'h0080);
    w(3'd2, 0, 0, 16'h0100);
    w(3'd3, 0, 0, 16'h0100);
    step("t6_step2_wait");
    w(3'd5, 0, 0, 16'h0100);
    dense(16'h1, "t6_dense2_wait");
    rd(3'd7, 32'h0000_0080, "t6_h_from_zero");
    rd(3'd6, 32'h1, "t6_step_after_rst");
    run_table();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
